// File: rtl/cell_btn_input_pkg.sv
// Shared constants for the Michi board input path: FSM state encodings and cell index sizing.
// Also consumed by the board and win-check blocks.
package cell_btn_input_pkg;

    localparam int unsigned N_CELLS    = 9;
    localparam int unsigned CELL_IDX_W = 4;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ARM  = 2'd1;
    localparam logic [1:0] HELD = 2'd2;
    localparam logic [1:0] REL  = 2'd3;

endpackage

// File: rtl/cell_btn_input_if.sv
// Button-side and board-side signal bundle of the cell input stage.
// The master drives buttons/enable; the slave (input stage) returns strobe, index and busy.
interface cell_btn_input_if #(
    parameter int unsigned N_BTN = 9
);
    import cell_btn_input_pkg::*;

    logic [N_BTN-1:0]      btn;
    logic                  en;
    logic                  cell_valid;
    logic [CELL_IDX_W-1:0] cell_idx;
    logic                  busy;

    modport master (
        output btn,
        output en,
        input  cell_valid,
        input  cell_idx,
        input  busy
    );

    modport slave (
        input  btn,
        input  en,
        output cell_valid,
        output cell_idx,
        output busy
    );

endinterface

// File: rtl/btn_sync.sv
// Per-bit two-flop synchronizer for asynchronous button levels.
// Both stages clear to 0 on asynchronous reset.
module btn_sync #(
    parameter int unsigned W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/cell_btn_input.sv
// Debounced cell push-button input: one registered cell index plus a single-cycle strobe per
// accepted press; releases and bounces never strobe.
module cell_btn_input
    import cell_btn_input_pkg::*;
#(
    parameter int unsigned N_BTN     = N_CELLS,
    parameter int unsigned DB_CYCLES = 500000,
    parameter int unsigned CNT_W     = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    cell_btn_input_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic [N_BTN-1:0]      s;
    logic [N_BTN-1:0]      cap_q, cap_d;
    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  valid_q, valid_d;
    logic [CELL_IDX_W-1:0] idx_q, idx_d;
    logic [CELL_IDX_W-1:0] enc_idx;
    logic                  s_one_hot;

    btn_sync #(
        .W (N_BTN)
    ) u_btn_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.btn),
        .q     (s)
    );

    assign s_one_hot = (s != '0) && ((s & (s - N_BTN'(1))) == '0);

    // cap is always one-hot here, so OR-ing the set bit positions yields its index.
    always_comb begin
        enc_idx = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if (cap_q[i]) enc_idx = enc_idx | CELL_IDX_W'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        cap_d   = cap_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (bus.en && s_one_hot) begin
                    cap_d   = s;
                    cnt_d   = '0;
                    state_d = ARM;
                end
            end
            ARM: begin
                if (s != cap_q) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    valid_d = 1'b1;
                    idx_d   = enc_idx;
                    state_d = HELD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (s == '0) begin
                    cnt_d   = '0;
                    state_d = REL;
                end
            end
            REL: begin
                if (s != '0) begin
                    cnt_d   = '0;
                    state_d = HELD;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cap_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cap_q   <= cap_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
        end
    end

    assign bus.cell_valid = valid_q;
    assign bus.cell_idx   = idx_q;
    assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_cell_btn_input.sv
// Directed bench for cell_btn_input with DB_CYCLES=4: press, bounce, multi-press, release
// glitches, enable gating and mid-press reset.
module tb_cell_btn_input;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    cell_btn_input_if #(.N_BTN(9)) bus ();

    cell_btn_input #(
        .N_BTN     (9),
        .DB_CYCLES (4),
        .CNT_W     (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs n cycles, sampling on each negedge; counts strobes and keeps the last strobed index.
    task automatic run(input int n, output int strobes, output logic [3:0] idx);
        strobes = 0;
        idx     = 4'hf;
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.cell_valid === 1'b1) begin
                strobes++;
                idx = bus.cell_idx;
            end
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        bus.btn = '0;
        bus.en  = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.cell_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid got %b exp 0", bus.cell_valid);
        end
        checks++;
        if (bus.cell_idx !== 4'd0) begin
            errors++; $display("FAIL reset_idx got %0d exp 0", bus.cell_idx);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy got %b exp 0", bus.busy);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_clean_press();
        int strobes;
        logic [3:0] idx;
        strobes = 0;
        idx = '0;
        bus.btn = 9'h010;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (e == 2) begin
                checks++;
                if (bus.busy !== 1'b0) begin
                    errors++; $display("FAIL press_busy_e2 got %b exp 0", bus.busy);
                end
            end
            if (e == 3) begin
                checks++;
                if (bus.busy !== 1'b1) begin
                    errors++; $display("FAIL press_busy_e3 got %b exp 1", bus.busy);
                end
            end
            if (e == 7) begin
                checks++;
                if (bus.cell_valid !== 1'b1 || bus.cell_idx !== 4'd4) begin
                    errors++;
                    $display("FAIL press_strobe_e7 got valid=%b idx=%0d exp valid=1 idx=4",
                             bus.cell_valid, bus.cell_idx);
                end
            end
            if (bus.cell_valid === 1'b1) strobes++;
        end
        checks++;
        if (strobes != 1) begin
            errors++; $display("FAIL press_count got %0d exp 1", strobes);
        end
        bus.btn = '0;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (e == 6) begin
                checks++;
                if (bus.busy !== 1'b1) begin
                    errors++; $display("FAIL release_busy_e6 got %b exp 1", bus.busy);
                end
            end
            if (e == 7) begin
                checks++;
                if (bus.busy !== 1'b0) begin
                    errors++; $display("FAIL release_busy_e7 got %b exp 0", bus.busy);
                end
            end
            if (bus.cell_valid === 1'b1) begin
                checks++;
                errors++; $display("FAIL release_strobe got 1 exp 0");
            end
        end
        idx = bus.cell_idx;
        checks++;
        if (idx !== 4'd4) begin
            errors++; $display("FAIL press_idx_hold got %0d exp 4", idx);
        end
    endtask

    task automatic test_bounce();
        int bounce_strobes;
        int s1;
        int s2;
        logic [3:0] idx;
        bounce_strobes = 0;
        for (int k = 0; k < 5; k++) begin
            bus.btn = (k % 2 == 0) ? 9'h001 : 9'h000;
            run(2, s1, idx);
            bounce_strobes += s1;
        end
        checks++;
        if (bounce_strobes != 0) begin
            errors++; $display("FAIL bounce_no_strobe got %0d exp 0", bounce_strobes);
        end
        bus.btn = 9'h001;
        run(12, s2, idx);
        checks++;
        if (s2 != 1 || idx !== 4'd0) begin
            errors++; $display("FAIL bounce_strobe got count=%0d idx=%0d exp count=1 idx=0", s2, idx);
        end
        bus.btn = '0;
        run(10, s1, idx);
        checks++;
        if (bus.busy !== 1'b0 || s1 != 0) begin
            errors++; $display("FAIL bounce_release got busy=%b count=%0d exp 0 0", bus.busy, s1);
        end
    endtask

    task automatic test_multi_press();
        int s1;
        logic [3:0] idx;
        bus.btn = 9'h003;
        run(10, s1, idx);
        checks++;
        if (s1 != 0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL multi_ignored got count=%0d busy=%b exp 0 0", s1, bus.busy);
        end
        bus.btn = 9'h002;
        run(12, s1, idx);
        checks++;
        if (s1 != 1 || idx !== 4'd1) begin
            errors++; $display("FAIL multi_single got count=%0d idx=%0d exp count=1 idx=1", s1, idx);
        end
        bus.btn = '0;
        run(10, s1, idx);
    endtask

    task automatic test_hold_release_glitch();
        int s1;
        int rel_strobes;
        logic [3:0] idx;
        logic [8:0] pat [7];
        int         len [7];
        pat = '{9'h000, 9'h100, 9'h000, 9'h100, 9'h000, 9'h100, 9'h000};
        len = '{2, 1, 2, 1, 1, 1, 12};
        bus.btn = 9'h100;
        run(12, s1, idx);
        checks++;
        if (s1 != 1 || idx !== 4'd8) begin
            errors++; $display("FAIL hold_strobe got count=%0d idx=%0d exp count=1 idx=8", s1, idx);
        end
        rel_strobes = 0;
        for (int k = 0; k < 7; k++) begin
            bus.btn = pat[k];
            run(len[k], s1, idx);
            rel_strobes += s1;
        end
        checks++;
        if (rel_strobes != 0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL release_glitch got count=%0d busy=%b exp 0 0", rel_strobes, bus.busy);
        end
        bus.btn = 9'h100;
        run(12, s1, idx);
        checks++;
        if (s1 != 1 || idx !== 4'd8) begin
            errors++; $display("FAIL second_press got count=%0d idx=%0d exp count=1 idx=8", s1, idx);
        end
        bus.btn = '0;
        run(10, s1, idx);
    endtask

    task automatic test_enable();
        int s1;
        logic [3:0] idx;
        bus.en  = 1'b0;
        bus.btn = 9'h020;
        run(10, s1, idx);
        checks++;
        if (s1 != 0 || bus.busy !== 1'b0 || bus.cell_idx !== 4'd8) begin
            errors++;
            $display("FAIL en_low got count=%0d busy=%b idx=%0d exp 0 0 8", s1, bus.busy, bus.cell_idx);
        end
        bus.en = 1'b1;
        run(12, s1, idx);
        checks++;
        if (s1 != 1 || idx !== 4'd5) begin
            errors++; $display("FAIL en_high got count=%0d idx=%0d exp count=1 idx=5", s1, idx);
        end
        bus.btn = '0;
        run(10, s1, idx);
    endtask

    task automatic test_reset_mid_press();
        int s1;
        logic [3:0] idx;
        bus.btn = 9'h080;
        run(4, s1, idx);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++; $display("FAIL arm_busy got %b exp 1", bus.busy);
        end
        for (int pass = 0; pass < 2; pass++) begin
            #1 rst_n = 1'b0;
            #1;
            checks++;
            if (bus.busy !== 1'b0 || bus.cell_valid !== 1'b0 || bus.cell_idx !== 4'd0) begin
                errors++;
                $display("FAIL rst_async_%0d got busy=%b valid=%b idx=%0d exp 0 0 0",
                         pass, bus.busy, bus.cell_valid, bus.cell_idx);
            end
            @(negedge clk);
            rst_n = 1'b1;
            s1 = 0;
            for (int e = 1; e <= 9; e++) begin
                @(posedge clk);
                @(negedge clk);
                if (e < 7 && bus.cell_valid === 1'b1) s1++;
                if (e == 7) begin
                    checks++;
                    if (bus.cell_valid !== 1'b1 || bus.cell_idx !== 4'd7 || s1 != 0) begin
                        errors++;
                        $display("FAIL rst_restrobe_%0d got valid=%b idx=%0d early=%0d exp 1 7 0",
                                 pass, bus.cell_valid, bus.cell_idx, s1);
                    end
                end
            end
            // Second pass resets from HELD.
        end
        bus.btn = '0;
        run(10, s1, idx);
        checks++;
        if (bus.busy !== 1'b0 || s1 != 0) begin
            errors++; $display("FAIL rst_final got busy=%b count=%0d exp 0 0", bus.busy, s1);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.btn = '0;
        bus.en  = 1'b1;
        test_reset();
        test_clean_press();
        test_bounce();
        test_multi_press();
        test_hold_release_glitch();
        test_enable();
        test_reset_mid_press();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
